// File: rtl/boot_mode_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : boot_mode_ctrl_if                                            |
// | Description : Peripheral register bus used by boot_mode_ctrl.              |
// |               ren/wen   - read / write strobes (one cycle each)            |
// |               raddr     - word index of the register being read            |
// |               waddr     - word index of the register being written         |
// |               wdata     - write data                                       |
// |               rdata     - registered read data, valid the cycle after ren  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface boot_mode_ctrl_if;
  logic        ren;
  logic        wen;
  logic [1:0]  raddr;
  logic [1:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output ren, wen, raddr, waddr, wdata,
    input  rdata
  );

  modport slave (
    input  ren, wen, raddr, waddr, wdata,
    output rdata
  );
endinterface
`default_nettype wire

// File: rtl/boot_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : boot_mode_ctrl                                               |
// | Description : Boot / download controller. Selects which of NUM_IMAGES      |
// |               instruction sources feeds the core (image 0 = bootloader),   |
// |               runs an armed switch sequence that holds the core's PC in    |
// |               reset for SWITCH_DELAY cycles, optional auto-boot to image 1,|
// |               error flag, and an auto-incrementing string ROM reader.      |
// | Ports       : hb_clk, rst_n    - clock, async active-low reset             |
// |               bus              - register bus (slave modport)              |
// |               instr_in         - flattened instruction words, 32 per image |
// |               instruction      - selected instruction (comb. mux)          |
// |               pc_rst_req       - high while a switch is armed              |
// |               cur_image        - active image index                        |
// |               download_mode    - strap input, reported in STATUS           |
// |               str_addr/str_data- external combinational string ROM        |
// | Registers   : 0 CTRL/STATUS, 1 STR_ADDR, 2 STR_DATA, 3 AUTOBOOT            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module boot_mode_ctrl #(
  parameter int         NUM_IMAGES      = 2,
  parameter int         STR_AW          = 6,
  parameter int         SWITCH_DELAY    = 1,
  parameter int         AUTOBOOT_CYCLES = 0,
  parameter logic [7:0] SWITCH_KEY      = 8'hF0
) (
  input  wire logic                      hb_clk,
  input  wire logic                      rst_n,
  boot_mode_ctrl_if.slave                bus,
  input  wire logic [32*NUM_IMAGES-1:0]  instr_in,
  output logic      [31:0]               instruction,
  output logic                           pc_rst_req,
  output logic      [3:0]                cur_image,
  input  wire logic                      download_mode,
  output logic      [STR_AW-1:0]         str_addr,
  input  wire logic [7:0]                str_data
);

  localparam int c_AB_W  = (AUTOBOOT_CYCLES > 1) ? $clog2(AUTOBOOT_CYCLES + 1) : 1;
  localparam int c_DLY_W = (SWITCH_DELAY > 1) ? $clog2(SWITCH_DELAY + 1) : 1;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_target;
  logic [3:0]          r_cur_image;
  logic [c_DLY_W-1:0]  r_dly_cnt;
  logic [c_AB_W-1:0]   r_ab_cnt;
  logic                r_ab_en;
  logic                r_err;
  logic [STR_AW-1:0]   r_str_ptr;
  logic [31:0]         r_rdata;

  logic                w_arm;
  logic [3:0]          w_arm_tgt;
  logic                w_err_set;
  logic [31:0]         w_rdata_nxt;

  // Only the key and target fields of wdata are decoded.
  wire w_unused_wdata = &{1'b0, bus.wdata};

  wire       w_ctrl_wr  = bus.wen && (bus.waddr == 2'd0);
  wire       w_str_wr   = bus.wen && (bus.waddr == 2'd1);
  wire       w_ab_wr    = bus.wen && (bus.waddr == 2'd3);
  wire       w_stat_rd  = bus.ren && (bus.raddr == 2'd0);
  wire       w_str_rd   = bus.ren && (bus.raddr == 2'd2);
  wire       w_key_ok   = (bus.wdata[7:0] == SWITCH_KEY);
  wire [3:0] w_tgt      = bus.wdata[11:8];
  wire       w_tgt_lt_n = ({1'b0, w_tgt} < 5'(NUM_IMAGES));

  // Fires on the edge where the countdown goes 1 -> 0, so ARMED is entered on
  // the same edge the count expires. An AUTOBOOT write in that cycle wins.
  wire w_ab_dec  = (r_state == ST_BOOT) && r_ab_en && !download_mode &&
                   (r_ab_cnt != '0);
  wire w_ab_fire = w_ab_dec && (r_ab_cnt == c_AB_W'(1)) && !w_ab_wr;

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_arm_tgt   = r_target;
    w_err_set   = 1'b0;
    unique case (r_state)
      ST_BOOT: begin
        // The bootloader cannot re-select itself, so target 0 is invalid here.
        if (w_ctrl_wr && w_key_ok && w_tgt_lt_n && (w_tgt != 4'd0)) begin
          w_arm     = 1'b1;
          w_arm_tgt = w_tgt;
        end else if (w_ab_fire) begin
          w_arm     = 1'b1;
          w_arm_tgt = 4'd1;
        end
        if (w_ctrl_wr && w_key_ok && (!w_tgt_lt_n || (w_tgt == 4'd0)))
          w_err_set = 1'b1;
      end
      ST_ARMED: begin
        // Control writes are ignored until the switch completes.
        if (r_dly_cnt <= c_DLY_W'(1))
          w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_ctrl_wr && w_key_ok) begin
          if (w_tgt_lt_n) begin
            w_arm     = 1'b1;
            w_arm_tgt = w_tgt;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
    if (w_arm)
      w_state_nxt = ST_ARMED;
  end

  always_comb begin
    w_rdata_nxt = 32'd0;
    case (bus.raddr)
      2'd0: w_rdata_nxt = {16'd0, r_err, 5'd0, r_state, r_cur_image, 3'd0, download_mode};
      2'd2: w_rdata_nxt = {24'd0, str_data};
      2'd3: w_rdata_nxt = 32'(r_ab_cnt);
      default: w_rdata_nxt = 32'd0;
    endcase
  end

  always_ff @(posedge hb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_BOOT;
      r_target    <= 4'd0;
      r_cur_image <= 4'd0;
      r_dly_cnt   <= '0;
      r_ab_cnt    <= c_AB_W'(AUTOBOOT_CYCLES);
      r_ab_en     <= (AUTOBOOT_CYCLES != 0);
      r_err       <= 1'b0;
      r_str_ptr   <= '0;
      r_rdata     <= 32'd0;
    end else begin
      r_state <= w_state_nxt;

      if (w_arm) begin
        r_target  <= w_arm_tgt;
        r_dly_cnt <= c_DLY_W'(SWITCH_DELAY);
      end else if ((r_state == ST_ARMED) && (r_dly_cnt != '0)) begin
        r_dly_cnt <= r_dly_cnt - c_DLY_W'(1);
      end

      if ((r_state == ST_ARMED) && (w_state_nxt == ST_RUN))
        r_cur_image <= r_target;

      if (w_ab_wr) begin
        r_ab_cnt <= '0;
        r_ab_en  <= 1'b0;
      end else if (w_ab_dec) begin
        r_ab_cnt <= r_ab_cnt - c_AB_W'(1);
      end

      // A new error in the same cycle as a status read must not be lost.
      if (w_err_set)
        r_err <= 1'b1;
      else if (w_stat_rd)
        r_err <= 1'b0;

      // An address write overrides the post-increment of a concurrent read.
      if (w_str_wr)
        r_str_ptr <= bus.wdata[STR_AW-1:0];
      else if (w_str_rd)
        r_str_ptr <= r_str_ptr + STR_AW'(1);

      if (bus.ren)
        r_rdata <= w_rdata_nxt;
    end
  end

  always_comb begin
    instruction = instr_in[31:0];
    for (int k = 0; k < NUM_IMAGES; k++) begin
      if (r_cur_image == 4'(k))
        instruction = instr_in[32*k +: 32];
    end
  end

  // Bypass so a combinational ROM presents the new byte in the write cycle.
  assign str_addr   = w_str_wr ? bus.wdata[STR_AW-1:0] : r_str_ptr;
  assign pc_rst_req = (r_state == ST_ARMED);
  assign cur_image  = r_cur_image;
  assign bus.rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_boot_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_boot_mode_ctrl                                            |
// | Description : Directed self-checking bench for boot_mode_ctrl with         |
// |               NUM_IMAGES=2, STR_AW=6, SWITCH_DELAY=3, AUTOBOOT_CYCLES=10.  |
// |               String ROM model: data = {2'b00, addr} ^ 8'hA5.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_boot_mode_ctrl;

  localparam logic [31:0] c_IMG0 = 32'h1111_0000;
  localparam logic [31:0] c_IMG1 = 32'h2222_0001;

  logic        hb_clk = 1'b0;
  logic        rst_n;
  logic        download_mode;
  logic [63:0] instr_in;
  logic [31:0] instruction;
  logic        pc_rst_req;
  logic [3:0]  cur_image;
  logic [5:0]  str_addr;
  logic [7:0]  str_data;
  logic [31:0] rd;

  int n_checks = 0;
  int n_errors = 0;

  boot_mode_ctrl_if bus_if ();

  boot_mode_ctrl #(
    .NUM_IMAGES      (2),
    .STR_AW          (6),
    .SWITCH_DELAY    (3),
    .AUTOBOOT_CYCLES (10),
    .SWITCH_KEY      (8'hF0)
  ) dut (
    .hb_clk        (hb_clk),
    .rst_n         (rst_n),
    .bus           (bus_if),
    .instr_in      (instr_in),
    .instruction   (instruction),
    .pc_rst_req    (pc_rst_req),
    .cur_image     (cur_image),
    .download_mode (download_mode),
    .str_addr      (str_addr),
    .str_data      (str_data)
  );

  always #5 hb_clk = ~hb_clk;

  assign instr_in = {c_IMG1, c_IMG0};
  assign str_data = {2'b00, str_addr} ^ 8'hA5;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All bus tasks are entered 1 ns after a rising edge and return likewise.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.wen   = 1'b1;
    bus_if.waddr = a;
    bus_if.wdata = d;
    @(posedge hb_clk); #1;
    bus_if.wen   = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_if.ren   = 1'b1;
    bus_if.raddr = a;
    @(posedge hb_clk); #1;
    bus_if.ren   = 1'b0;
    d = bus_if.rdata;
  endtask

  task automatic restart(input logic dl);
    rst_n = 1'b0;
    download_mode = dl;
    @(posedge hb_clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    download_mode = 1'b1;
    bus_if.ren    = 1'b0;
    bus_if.wen    = 1'b0;
    bus_if.raddr  = 2'd0;
    bus_if.waddr  = 2'd0;
    bus_if.wdata  = 32'd0;
    repeat (2) @(posedge hb_clk);
    #1;
    chk("rst_pc",    32'(pc_rst_req), 32'd0);
    chk("rst_img",   32'(cur_image),  32'd0);
    chk("rst_instr", instruction,     c_IMG0);
    chk("rst_rdata", bus_if.rdata,    32'd0);
    chk("rst_saddr", 32'(str_addr),   32'd0);
    rst_n = 1'b1;

    bus_read(2'd0, rd); chk("status_dl1", rd, 32'h0000_0001);
    bus_read(2'd3, rd); chk("ab_frozen", rd, 32'd10);

    // String ROM reader with wrap.
    bus_if.wen = 1'b1; bus_if.waddr = 2'd1; bus_if.wdata = 32'h3E;
    #1 chk("saddr_bypass", 32'(str_addr), 32'h3E);
    @(posedge hb_clk); #1; bus_if.wen = 1'b0;
    chk("saddr_ptr", 32'(str_addr), 32'h3E);
    bus_read(2'd2, rd); chk("sdata_3e", rd, 32'h9B); chk("saddr_3f", 32'(str_addr), 32'h3F);
    bus_read(2'd2, rd); chk("sdata_3f", rd, 32'h9A); chk("saddr_00", 32'(str_addr), 32'h00);
    bus_read(2'd2, rd); chk("sdata_00", rd, 32'hA5); chk("saddr_01", 32'(str_addr), 32'h01);
    bus_read(2'd1, rd); chk("saddr_rd0", rd, 32'd0);

    // Address write and data read together: write wins, no increment.
    bus_if.wen = 1'b1; bus_if.waddr = 2'd1; bus_if.wdata = 32'h10;
    bus_if.ren = 1'b1; bus_if.raddr = 2'd2;
    @(posedge hb_clk); #1;
    bus_if.wen = 1'b0; bus_if.ren = 1'b0;
    chk("wr_rd_data", bus_if.rdata, 32'hB5);
    chk("wr_rd_ptr", 32'(str_addr), 32'h10);

    // Invalid targets and non-key writes in BOOT.
    bus_write(2'd0, 32'h5F0);
    chk("bad_tgt_pc", 32'(pc_rst_req), 32'd0);
    bus_read(2'd0, rd); chk("err_set", rd, 32'h0000_8001);
    bus_read(2'd0, rd); chk("err_clr", rd, 32'h0000_0001);
    bus_write(2'd0, 32'h0F0);
    bus_read(2'd0, rd); chk("err_tgt0", rd, 32'h0000_8001);
    bus_write(2'd0, 32'h1A5);
    chk("nokey_pc", 32'(pc_rst_req), 32'd0);
    bus_read(2'd0, rd); chk("nokey_stat", rd, 32'h0000_0001);

    // Error set and status read in the same cycle.
    bus_if.wen = 1'b1; bus_if.waddr = 2'd0; bus_if.wdata = 32'h5F0;
    bus_if.ren = 1'b1; bus_if.raddr = 2'd0;
    @(posedge hb_clk); #1;
    bus_if.wen = 1'b0; bus_if.ren = 1'b0;
    chk("setrd_old", bus_if.rdata, 32'h0000_0001);
    bus_read(2'd0, rd); chk("setrd_wins", rd, 32'h0000_8001);

    // Switch to image 1: pc_rst_req for exactly 3 cycles.
    bus_write(2'd0, 32'h1F0);
    chk("sw_pc1", 32'(pc_rst_req), 32'd1);
    chk("sw_img_hold", 32'(cur_image), 32'd0);
    @(posedge hb_clk); #1; chk("sw_pc2", 32'(pc_rst_req), 32'd1);
    @(posedge hb_clk); #1; chk("sw_pc3", 32'(pc_rst_req), 32'd1);
    @(posedge hb_clk); #1;
    chk("sw_pc_end", 32'(pc_rst_req), 32'd0);
    chk("sw_img",    32'(cur_image),  32'd1);
    chk("sw_instr",  instruction,     c_IMG1);
    bus_read(2'd0, rd); chk("sw_status", rd, 32'h0000_0211);

    // RUN: back to image 0; a write while ARMED is ignored.
    bus_write(2'd0, 32'h0F0);
    bus_write(2'd0, 32'h1F0);
    chk("arm_ign_pc", 32'(pc_rst_req), 32'd1);
    @(posedge hb_clk); #1; chk("arm_ign_pc2", 32'(pc_rst_req), 32'd1);
    @(posedge hb_clk); #1;
    chk("ret_pc",    32'(pc_rst_req), 32'd0);
    chk("ret_img",   32'(cur_image),  32'd0);
    chk("ret_instr", instruction,     c_IMG0);
    bus_read(2'd0, rd); chk("ret_status", rd, 32'h0000_0201);
    bus_write(2'd0, 32'h2F0);
    bus_read(2'd0, rd); chk("run_err", rd, 32'h0000_8201);

    // Asynchronous reset mid-ARMED.
    bus_write(2'd0, 32'h1F0);
    chk("mid_pc", 32'(pc_rst_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc",    32'(pc_rst_req), 32'd0);
    chk("arst_img",   32'(cur_image),  32'd0);
    chk("arst_instr", instruction,     c_IMG0);
    chk("arst_rdata", bus_if.rdata,    32'd0);

    // Auto-boot with download_mode=0: ARMED on edge 10 after release.
    restart(1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge hb_clk); #1;
      chk($sformatf("ab_cyc%0d", i), 32'(pc_rst_req), (i == 10) ? 32'd1 : 32'd0);
    end
    repeat (3) @(posedge hb_clk);
    #1;
    chk("ab_img", 32'(cur_image), 32'd1);
    chk("ab_pc",  32'(pc_rst_req), 32'd0);

    // Auto-boot frozen by download_mode=1.
    restart(1'b1);
    repeat (15) @(posedge hb_clk);
    #1;
    chk("dl_pc", 32'(pc_rst_req), 32'd0);
    bus_read(2'd3, rd); chk("dl_cnt", rd, 32'd10);
    bus_read(2'd0, rd); chk("dl_status", rd, 32'h0000_0001);

    // Auto-boot cancelled by an AUTOBOOT write on edge 4.
    restart(1'b0);
    repeat (2) @(posedge hb_clk);
    #1;
    bus_read(2'd3, rd); chk("ab_cnt8", rd, 32'd8);
    bus_write(2'd3, 32'd0);
    repeat (12) @(posedge hb_clk);
    #1;
    chk("abw_pc", 32'(pc_rst_req), 32'd0);
    bus_read(2'd3, rd); chk("abw_cnt", rd, 32'd0);
    bus_read(2'd0, rd); chk("abw_status", rd, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boot_mode_ctrl.md
Name: boot_mode_ctrl

Overview:
Parametrised boot and download controller in the system-peripheral space. It selects which of NUM_IMAGES instruction sources feeds the core; image 0 is the bootloader. It adds an armed switch sequence with a programmable PC-reset window, an optional auto-boot timeout, error reporting, and an auto-incrementing reader for an external string ROM.

Parameters:
NUM_IMAGES, 2, number of instruction sources (2..16); image 0 is the bootloader.
STR_AW, 6, string ROM address width; depth is 2**STR_AW bytes.
SWITCH_DELAY, 1, cycles pc_rst_req is held before the mux changes (1..255).
AUTOBOOT_CYCLES, 0, cycles in BOOT before automatic switch to image 1; 0 disables auto-boot.
SWITCH_KEY, 8'hF0, CTRL[7:0] value that requests a switch.

Ports:
hb_clk  in  1  system bus clock.
rst_n  in  1  async active-low reset.
instr_in  in  32*NUM_IMAGES  flattened instruction words; image k occupies [32k+31:32k].
instruction  out  32  selected instruction, combinational mux on cur_image.
pc_rst_req  out  1  high while ARMED; the core forces PC to 0.
cur_image  out  4  active image index.
download_mode  in  1  strap input, reported in STATUS.
ren, wen  in  1  peripheral select read / write strobes.
raddr, waddr  in  2  word register index.
wdata  in  32  write data.
rdata  out  32  registered read data.
str_addr  out  STR_AW  string ROM address (bypassed).
str_data  in  8  string ROM data (combinational ROM).

Behaviour:
- Reset: state=BOOT, cur_image=0, pc_rst_req=0, rdata=0, str pointer=0, err=0, autoboot counter=AUTOBOOT_CYCLES.
- Register map:
  - 0 CTRL/STATUS. Write: [7:0] key, [11:8] target.
  - 0 read: {16'b0, err[15], 5'b0, state[9:8], cur_image[7:4], 3'b0, download_mode[0]}; reading clears err in the same cycle it is sampled.
  - 1 STR_ADDR. Write only; reads return 0.
  - 2 STR_DATA. Read returns {24'b0, str_data}, then post-increments the pointer, wrapping 2**STR_AW-1 -> 0.
  - 3 AUTOBOOT. Read returns the remaining count. Any write sets the count to 0 and disables auto-boot until reset.
- rdata: updated only on the cycle after ren; holds its value otherwise.
- str_addr: equals wdata[STR_AW-1:0] on a STR_ADDR write cycle, otherwise the pointer.
- Simultaneous STR_ADDR write and STR_DATA read: the write wins. The read returns data at the new address and the pointer becomes that address, not incremented.
- FSM states: BOOT(0), ARMED(1), RUN(2).
  - BOOT -> ARMED: a CTRL write with key==SWITCH_KEY and 1<=target<NUM_IMAGES. Latch target; load delay counter with SWITCH_DELAY.
  - A key match with invalid target (0 or >=NUM_IMAGES): no transition, err<=1.
  - A non-key write: ignored.
  - BOOT -> ARMED also when the autoboot counter, decremented each BOOT cycle while nonzero and enabled, reaches 0 with download_mode==0. Target is 1.
  - With download_mode==1 the counter freezes.
  - ARMED: pc_rst_req=1, counter decrements. When it reaches 0 (after exactly SWITCH_DELAY ARMED cycles) -> RUN, cur_image<=target, pc_rst_req<=0. CTRL writes in ARMED are ignored.
  - RUN: a CTRL write with key==SWITCH_KEY and valid target (target 0 allowed) re-arms and returns through ARMED. Invalid target sets err.
- Err-set and status-read in the same cycle: set wins.
- rst_n assertion in any state, including mid-ARMED: immediate return to reset values; instruction reverts to image 0 asynchronously.
- Widths: target compared as unsigned 4-bit; counters sized to the parameter (minimum 1 bit).

Test Plan:
- Reset, then read CTRL with download_mode=1 -> rdata=0x00000001; instruction==instr_in image 0; pc_rst_req=0.
- Write STR_ADDR=0x3E, then 3 STR_DATA reads -> ROM bytes at 0x3E, 0x3F, 0x00 (wrap); str_addr tracks each step.
- SWITCH_DELAY=3: write CTRL=0x1F0 -> pc_rst_req high exactly 3 cycles starting the cycle after the write; then cur_image=1, instruction=image 1, STATUS state=2.
- Write CTRL=0x5F0 with NUM_IMAGES=2 -> state stays BOOT, STATUS bit15=1; next STATUS read returns bit15=0.
- AUTOBOOT_CYCLES=10, download_mode=0, no writes -> ARMED entered on cycle 10 after reset. Repeat with download_mode=1 -> stays BOOT. Repeat with an AUTOBOOT write at cycle 4 -> stays BOOT, count reads 0.
- rst_n pulsed low mid-ARMED -> pc_rst_req=0, cur_image=0, state=BOOT asynchronously, before the next clock edge.
